audio_clock_regeneration_receiver: RTL

// Sink-side counterpart of the HDMI ACR packet generator (HDMI 1.4a 5.3.3, 7.2.3). Decodes received

---
 rtl/audio_clock_regeneration_receiver_pkg.sv | 35 +++
 rtl/audio_clock_regeneration_receiver_if.sv | 9 +
 rtl/audio_clock_regeneration_receiver_divider.sv | 48 ++++
 rtl/audio_clock_regeneration_receiver.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/audio_clock_regeneration_receiver_pkg.sv
// Shared types and field layout for the HDMI Audio Clock Regeneration receiver.
package hdmi_acr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } acr_state_t;

    localparam logic [7:0] ACR_PACKET_TYPE = 8'h01;

    // Byte lanes of N and CTS inside one 56-bit subpacket.
    localparam int N_HI_LSB    = 32;
    localparam int N_MID_LSB   = 40;
    localparam int N_LO_LSB    = 48;
    localparam int CTS_HI_LSB  = 8;
    localparam int CTS_MID_LSB = 16;
    localparam int CTS_LO_LSB  = 24;

    // audio_tick to sample_tick ratio is 2**PRESCALE_W = 128.
    localparam int PRESCALE_W = 7;

    typedef struct packed {
        logic [19:0] n;
        logic [19:0] cts;
    } acr_params_t;

    function automatic acr_params_t decode_subpacket(input logic [55:0] sp);
        acr_params_t p;
        p.n   = {sp[N_HI_LSB +: 4], sp[N_MID_LSB +: 8], sp[N_LO_LSB +: 8]};
        p.cts = {sp[CTS_HI_LSB +: 4], sp[CTS_MID_LSB +: 8], sp[CTS_LO_LSB +: 8]};
        return p;
    endfunction

endpackage

// File: rtl/audio_clock_regeneration_receiver_if.sv
// Received-packet bus from the packet deserializer into the ACR receiver.
interface audio_clock_regeneration_receiver_if;
    logic             packet_valid;
    logic [23:0]      header;
    logic [3:0][55:0] sub;

    modport master (output packet_valid, header, sub);
    modport slave  (input  packet_valid, header, sub);
endinterface

// File: rtl/audio_clock_regeneration_receiver_divider.sv
// N/CTS fractional accumulator producing the 128*fs enable and the /128 fs enable.
module acr_fractional_divider
    import hdmi_acr_pkg::*;
#(
    parameter int ACC_W = 21
) (
    input  logic             clk_pixel,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [ACC_W-1:0] n,
    input  logic [ACC_W-1:0] cts,
    output logic             audio_tick,
    output logic             sample_tick
);

    logic [ACC_W-1:0]      acc_q;
    logic [ACC_W:0]        acc_sum;
    logic                  wrap;
    logic [PRESCALE_W-1:0] prescale_q;

    assign acc_sum = {1'b0, acc_q} + {1'b0, n};
    assign wrap    = (acc_sum >= {1'b0, cts});

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            acc_q       <= '0;
            prescale_q  <= '0;
            audio_tick  <= 1'b0;
            sample_tick <= 1'b0;
        end else if (!enable) begin
            acc_q       <= '0;
            prescale_q  <= '0;
            audio_tick  <= 1'b0;
            sample_tick <= 1'b0;
        end else begin
            audio_tick  <= wrap;
            sample_tick <= wrap && (prescale_q == '1);
            if (wrap) begin
                acc_q      <= ACC_W'(acc_sum - {1'b0, cts});
                prescale_q <= prescale_q + PRESCALE_W'(1);
            end else begin
                acc_q <= acc_sum[ACC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/audio_clock_regeneration_receiver.sv
// HDMI ACR sink: qualifies N/CTS packets, locks onto them and regenerates 128*fs on clk_pixel.
// Optional ACR_CTS_AVERAGE_EN: CTS in use is the mean of the last four accepted values.
module audio_clock_regeneration_receiver
    import hdmi_acr_pkg::*;
#(
    parameter int LOCK_COUNT     = 4,
    parameter int CTS_TOLERANCE  = 2,
    parameter int TIMEOUT_CYCLES = 4194304
) (
    input  logic                                clk_pixel,
    input  logic                                reset_n,
    audio_clock_regeneration_receiver_if.slave  pkt,
    output logic                                audio_tick,
    output logic                                sample_tick,
    output logic                                locked,
    output logic [19:0]                         n_value,
    output logic [19:0]                         cts_value,
    output logic                                packet_error
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

    acr_state_t     state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [TO_W-1:0]  timeout_q;
    logic [19:0]      n_q, cts_ref_q;
    logic             relatch, accept;

    acr_params_t rx;
    logic        is_acr, subs_identical, fields_ok, pkt_ok, pkt_bad;
    logic [19:0] cts_diff;
    logic        consistent, timeout_expired, div_enable;
    logic        header_unused;

    assign header_unused = ^pkt.header[23:8];

    assign rx             = decode_subpacket(pkt.sub[0]);
    assign is_acr         = pkt.packet_valid && (pkt.header[7:0] == ACR_PACKET_TYPE);
    assign subs_identical = (pkt.sub[0] == pkt.sub[1]) && (pkt.sub[0] == pkt.sub[2]) &&
                            (pkt.sub[0] == pkt.sub[3]);
    // 2*N <= CTS keeps the accumulator below CTS across any in-tolerance CTS change.
    assign fields_ok      = subs_identical && (rx.n != '0) && ({rx.n, 1'b0} <= {1'b0, rx.cts});
    assign pkt_ok         = is_acr && fields_ok;
    assign pkt_bad        = is_acr && !fields_ok;

    assign cts_diff   = (rx.cts > cts_ref_q) ? (rx.cts - cts_ref_q) : (cts_ref_q - rx.cts);
    assign consistent = (rx.n == n_q) && (cts_diff <= 20'(CTS_TOLERANCE));

    // A valid packet on the expiry cycle takes priority over the timeout.
    assign timeout_expired = !pkt_ok && (timeout_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        relatch = 1'b0;
        accept  = 1'b0;
        if (pkt_ok) begin
            case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    count_d = CNT_W'(1);
                    relatch = 1'b1;
                end
                ACQUIRE: begin
                    if (consistent) begin
                        accept  = 1'b1;
                        count_d = CNT_W'(count_q + 1'b1);
                        if (count_q == CNT_W'(LOCK_COUNT - 1)) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        relatch = 1'b1;
                        count_d = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (consistent) begin
                        accept = 1'b1;
                    end else begin
                        state_d = ACQUIRE;
                        relatch = 1'b1;
                        count_d = CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end else if (timeout_expired) begin
            state_d = IDLE;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            timeout_q    <= '0;
            n_q          <= '0;
            cts_ref_q    <= '0;
            locked       <= 1'b0;
            packet_error <= 1'b0;
        end else begin
            timeout_q    <= (pkt_ok || timeout_expired) ? '0 : timeout_q + TO_W'(1);
            locked       <= (state_q == LOCKED);
            packet_error <= pkt_bad;
            if (relatch) begin
                n_q       <= rx.n;
                cts_ref_q <= rx.cts;
            end else if (accept) begin
                cts_ref_q <= rx.cts;
            end
        end
    end

    assign n_value = n_q;

    // Ticks stop in the same cycle the FSM leaves LOCKED.
    assign div_enable = (state_q == LOCKED) && (state_d == LOCKED);

`ifdef ACR_CTS_AVERAGE_EN
    localparam int DIV_W = 23;

    logic [3:0][19:0] cts_hist_q;
    logic [21:0]      cts_sum;

    // NOTE: the four-entry history is plain flops, so it is reset with the rest of the state.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            cts_hist_q <= '0;
        end else if (relatch) begin
            cts_hist_q <= {4{rx.cts}};
        end else if (accept) begin
            cts_hist_q <= {cts_hist_q[2:0], rx.cts};
        end
    end

    assign cts_sum   = 22'(cts_hist_q[0]) + 22'(cts_hist_q[1]) +
                       22'(cts_hist_q[2]) + 22'(cts_hist_q[3]);
    assign cts_value = cts_sum[21:2];

    logic [DIV_W-1:0] div_n, div_cts;
    assign div_n   = {1'b0, n_q, 2'b00};
    assign div_cts = {1'b0, cts_sum};
`else
    localparam int DIV_W = 21;

    assign cts_value = cts_ref_q;

    logic [DIV_W-1:0] div_n, div_cts;
    assign div_n   = {1'b0, n_q};
    assign div_cts = {1'b0, cts_ref_q};
`endif

    acr_fractional_divider #(
        .ACC_W (DIV_W)
    ) u_divider (
        .clk_pixel   (clk_pixel),
        .reset_n     (reset_n),
        .enable      (div_enable),
        .n           (div_n),
        .cts         (div_cts),
        .audio_tick  (audio_tick),
        .sample_tick (sample_tick)
    );

endmodule
